alu_accumulator: RTL

- Accumulator (register A) plus adder/subtractor and flag register; the direct consumer of register B's output in the 8-bit bus microprocessor.
- Holds operand A loaded from the W bus and forms A+B or A−B combinationally against register B's output.
- Drives the result and the accumulator onto W-bus source lines under controller enables, and latches C/Z/S flags.
- Adds an iterative shift-and-add unsigned multiply (A×B) with a busy handshake for the extended instruction set.

---
 rtl/alu_accumulator_if.sv | 32 +++
 rtl/alu_accumulator.sv | 115 +++++++++++
 2 files changed

// File: rtl/alu_accumulator_if.sv
// Control, data and status lines between the controller/bus fabric and the
// accumulator/ALU block.
interface alu_accumulator_if #(
    parameter int WIDTH = 8
);
    logic             la_n;
    logic             ea;
    logic             su;
    logic             eu;
    logic             lf_n;
    logic             mul_start;
    logic [WIDTH-1:0] w_bus;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] acc_bus;
    logic [WIDTH-1:0] alu_bus;
    logic [WIDTH-1:0] prod_hi;
    logic             flag_c;
    logic             flag_z;
    logic             flag_s;
    logic             busy;
    logic             mul_done;

    modport master (
        output la_n, ea, su, eu, lf_n, mul_start, w_bus, b_in,
        input  acc_bus, alu_bus, prod_hi, flag_c, flag_z, flag_s, busy, mul_done
    );

    modport slave (
        input  la_n, ea, su, eu, lf_n, mul_start, w_bus, b_in,
        output acc_bus, alu_bus, prod_hi, flag_c, flag_z, flag_s, busy, mul_done
    );
endinterface

// File: rtl/alu_accumulator.sv
// Accumulator with add/subtract path, C/Z/S flags and an iterative
// shift-and-add unsigned multiplier (A x B) with a busy handshake.
module alu_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                clr,
    alu_accumulator_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_prod_hi;
    logic               r_flag_c;
    logic               r_flag_z;
    logic               r_flag_s;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_product;
    logic [CW-1:0]      r_count;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_operand;
    logic [2*WIDTH-1:0] w_step;
    logic               w_last;

    // Subtract is acc + ~b + 1, so carry-out means "no borrow".
    always_comb begin
        w_operand = bus.su ? ~bus.b_in : bus.b_in;
        w_sum     = {1'b0, r_acc} + {1'b0, w_operand} + {{WIDTH{1'b0}}, bus.su};
        w_step    = r_mplier[0] ? (r_product + r_mcand) : r_product;
        w_last    = (r_count == CW'(WIDTH - 1));
    end

    assign bus.acc_bus  = bus.ea ? r_acc : '0;
    assign bus.alu_bus  = bus.eu ? w_sum[WIDTH-1:0] : '0;
    assign bus.prod_hi  = r_prod_hi;
    assign bus.flag_c   = r_flag_c;
    assign bus.flag_z   = r_flag_z;
    assign bus.flag_s   = r_flag_s;
    assign bus.busy     = r_busy;
    assign bus.mul_done = r_done;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_prod_hi <= '0;
            r_flag_c  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_s  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.mul_start) begin
                        r_mcand   <= {{WIDTH{1'b0}}, bus.b_in};
                        r_mplier  <= r_acc;
                        r_product <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end else begin
                        if (!bus.la_n) r_acc <= bus.w_bus;
                        if (!bus.lf_n) begin
                            r_flag_c <= w_sum[WIDTH];
                            r_flag_z <= (w_sum[WIDTH-1:0] == '0);
                            r_flag_s <= w_sum[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    r_product <= w_step;
                    r_mcand   <= r_mcand << 1;
                    r_mplier  <= r_mplier >> 1;
                    r_count   <= r_count + 1'b1;
                    // Final step result goes straight to acc/prod_hi/flags on this edge.
                    if (w_last) begin
                        r_acc     <= w_step[WIDTH-1:0];
                        r_prod_hi <= w_step[2*WIDTH-1:WIDTH];
                        r_flag_c  <= (w_step[2*WIDTH-1:WIDTH] != '0);
                        r_flag_z  <= (w_step == '0);
                        r_flag_s  <= w_step[WIDTH-1];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
